// File: rtl/histogram_reader_if.sv
// Bundles the bin-memory read port and the per-bin output stream of histogram_reader.
interface histogram_reader_if #(
  parameter int SIZE       = 5,
  parameter int MAX_NUMBER = 127
);
  localparam int ADDR_W = $clog2(MAX_NUMBER);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [SIZE-1:0]   rd_data;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_bin;
  logic [SIZE-1:0]   out_count;
  logic              out_last;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output out_valid, out_bin, out_count, out_last,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  out_valid, out_bin, out_count, out_last,
    output out_ready
  );
endinterface

// File: rtl/histogram_reader.sv
// Scans every histogram bin in order, streams (bin, count) beats and tracks mode and total.
module histogram_reader #(
  parameter  int SIZE       = 5,
  parameter  int MAX_NUMBER = 127,
  localparam int ADDR_W     = $clog2(MAX_NUMBER),
  localparam int TOT_W      = SIZE + ADDR_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  histogram_reader_if.master      bus,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       mode_bin,
  output logic [SIZE-1:0]         mode_count,
  output logic [TOT_W-1:0]        total
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(MAX_NUMBER);

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              rd_en_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_bin_q;
  logic [SIZE-1:0]   out_count_q;
  logic              out_last_q;

  // The pointer doubles as the registered read address.
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = ptr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      ptr         <= '0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mode_bin    <= '0;
      mode_count  <= '0;
      total       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            ptr        <= '0;
            mode_bin   <= '0;
            mode_count <= '0;
            total      <= '0;
            busy       <= 1'b1;
            rd_en_q    <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          rd_en_q <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          out_count_q <= bus.rd_data;
          out_bin_q   <= ptr;
          out_valid_q <= 1'b1;
          out_last_q  <= (ptr == LAST_BIN);
          total       <= total + TOT_W'(bus.rd_data);
          // Strict compare keeps the lowest bin on ties.
          if (bus.rd_data > mode_count) begin
            mode_bin   <= ptr;
            mode_count <= bus.rd_data;
          end
          state <= PRESENT;
        end
        PRESENT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              ptr     <= ptr + 1'b1;
              rd_en_q <= 1'b1;
              state   <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/histogram_reader.md
HISTOGRAM_READER -- requirements
Module: histogram_reader

Interface
REQ-001 Parameter SIZE, default 5, width of one bin count.
REQ-002 Parameter MAX_NUMBER, default 127, highest bin index; MAX_NUMBER+1 SHALL be a power of two.
REQ-003 Derived ADDR_W = $clog2(MAX_NUMBER), bin index width; TOT_W = SIZE+ADDR_W, total width.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 START  input  1  scan request, sampled on rising edge.
REQ-007 rd_en  output  1  histogram memory read strobe.
REQ-008 rd_addr  output  ADDR_W  bin index being read.
REQ-009 rd_data  input  SIZE  bin count; valid in the cycle after rd_en=1.
REQ-010 out_valid  output  1  out_bin/out_count/out_last hold a beat.
REQ-011 out_ready  input  1  sink accepts the beat.
REQ-012 out_bin  output  ADDR_W  index of the presented bin.
REQ-013 out_count  output  SIZE  count of the presented bin.
REQ-014 out_last  output  1  presented bin is MAX_NUMBER.
REQ-015 busy  output  1  scan in progress.
REQ-016 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-017 mode_bin  output  ADDR_W  bin with the highest count in the last scan.
REQ-018 mode_count  output  SIZE  count of mode_bin.
REQ-019 total  output  TOT_W  sum of all counts in the last scan.

Function
REQ-020 The FSM SHALL have states IDLE, READ, WAIT, PRESENT, DONE; all outputs SHALL be registered.
REQ-021 IDLE: START=1 -> READ, bin pointer=0, mode_bin/mode_count/total cleared to 0, busy=1; START=0 -> stay.
REQ-022 READ: rd_en=1, rd_addr=bin pointer, for exactly one cycle -> WAIT.
REQ-023 WAIT: rd_en=0; at the edge ending WAIT, capture rd_data into out_count and the pointer into out_bin, set out_valid=1 and out_last=(pointer==MAX_NUMBER) -> PRESENT.
REQ-024 At the same capture edge, total += rd_data; if rd_data > mode_count (strictly), load mode_bin=pointer and mode_count=rd_data; ties keep the lower bin.
REQ-025 PRESENT: out_valid, out_bin, out_count and out_last SHALL be held stable while out_ready=0.
REQ-026 PRESENT with out_ready=1: beat accepted, out_valid=0 next cycle; if out_last -> DONE, else pointer+1 -> READ.
REQ-027 DONE: done=1 for one cycle, busy=0 next cycle -> IDLE.
REQ-028 Latency: START edge to rd_en = 1 cycle; rd_en to out_valid = 2 cycles; with out_ready held at 1, one beat per 3 cycles, full scan = 3*(MAX_NUMBER+1)+1 cycles to done.
REQ-029 START SHALL be ignored in every state except IDLE.
REQ-030 mode_bin, mode_count and total SHALL hold their final values from done until the next accepted START.
REQ-031 total SHALL not overflow: max (MAX_NUMBER+1)*(2^SIZE-1) fits TOT_W.
REQ-032 The pointer SHALL never advance past MAX_NUMBER; no wrap within a scan.

Reset
REQ-033 RST=0 SHALL immediately force IDLE, pointer=0, and drive every output to 0, including mid-scan and mid-beat.
REQ-034 After RST returns high, the block SHALL wait in IDLE for START; no partial scan resumes.

Verification
REQ-035 Memory model all zeros, START, out_ready=1 -> 128 beats, bins 0..127, counts 0, out_last only on bin 127, done once, mode_bin=0, mode_count=0, total=0.
REQ-036 Memory bin i = i mod 32 -> mode_bin=31, mode_count=31 (tie with 63/95/127 keeps 31), total=1984.
REQ-037 Bin 100=31, all others 1 -> mode_bin=100, mode_count=31, total=158.
REQ-038 out_ready=0 for 5 cycles while bin 3 is presented -> out_valid=1, out_bin=3, out_count stable all 5 cycles; bin 4 rd_en only after acceptance.
REQ-039 START pulsed at bin 20 mid-scan -> ignored; beat sequence and final results unchanged.
REQ-040 RST=0 while bin 50 is presented -> all outputs 0 within the same cycle; new START restarts at rd_addr=0 with total cleared.
